// File: rtl/grid_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module  : grid_stream_bridge
// Brief   : Streams a puzzle into the grid solver as one-hot cells, then
//           streams the captured solution (with fail flag) back out.
// Rev     : 1.0
// ============================================================================
module grid_stream_bridge #(
    parameter int N       = 3,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                              clk,
    input  logic                              rst_L,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [DW-1:0]                     in_data,
    output logic [N*N*N*N*N*N-1:0]            solver_init,
    output logic                              solver_start,
    input  logic                              solver_done,
    input  logic                              solver_fail,
    input  logic [N*N*N*N*$clog2(N*N+1)-1:0]  solver_vals,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DW-1:0]                     out_data,
    output logic                              out_last,
    output logic                              out_fail,
    output logic                              busy,
    output logic                              err_format
);
    localparam int WIDTH = N*N;
    localparam int CELLS = WIDTH*WIDTH;
    localparam int VW    = $clog2(WIDTH+1);
    localparam int IW    = $clog2(CELLS);
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(CELLS-1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT-1);

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_START  = 2'd1;
    localparam logic [1:0] ST_SOLVE  = 2'd2;
    localparam logic [1:0] ST_UNLOAD = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [CELLS*WIDTH-1:0] init_q, init_d;
    logic [CELLS*VW-1:0] buf_q, buf_d;
    logic                fail_q, fail_d;
    logic                err_q, err_d;
    logic [TW-1:0]       timer_q, timer_d;

    logic [WIDTH-1:0]    w_onehot;
    logic                w_bad;
    logic                w_timeout;

    always_comb begin
        for (int j = 0; j < WIDTH; j++) begin
            w_onehot[j] = (in_data == DW'(j+1));
        end
    end

    assign w_bad     = (in_data > DW'(WIDTH));
    assign w_timeout = (TIMEOUT != 0) && (timer_q == TMR_LAST);

    // State register
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:   if (in_valid && idx_q == IDX_LAST) state_d = ST_START;
            ST_START:  state_d = ST_SOLVE;
            ST_SOLVE:  if (solver_done || w_timeout) state_d = ST_UNLOAD;
            ST_UNLOAD: if (out_ready && idx_q == IDX_LAST) state_d = ST_LOAD;
            default:   state_d = ST_LOAD;
        endcase
    end

    // Datapath next values; done takes priority over timeout for the fail flag
    always_comb begin
        idx_d   = idx_q;
        init_d  = init_q;
        buf_d   = buf_q;
        fail_d  = fail_q;
        err_d   = err_q;
        timer_d = timer_q;
        case (state_q)
            ST_LOAD: begin
                if (in_valid) begin
                    init_d[idx_q*WIDTH +: WIDTH] = w_onehot;
                    err_d = ((idx_q == '0) ? 1'b0 : err_q) | w_bad;
                    idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
            ST_START: timer_d = '0;
            ST_SOLVE: begin
                if (TIMEOUT == 0 || timer_q != TMR_LAST) timer_d = timer_q + 1'b1;
                if (solver_done || w_timeout) begin
                    buf_d  = solver_vals;
                    fail_d = solver_done ? solver_fail : 1'b1;
                end
            end
            ST_UNLOAD: begin
                if (out_ready) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            idx_q   <= '0;
            init_q  <= '0;
            buf_q   <= '0;
            fail_q  <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            idx_q   <= idx_d;
            init_q  <= init_d;
            buf_q   <= buf_d;
            fail_q  <= fail_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    // Outputs decoded from registered state only, so they hold under backpressure
    always_comb begin
        in_ready     = 1'b0;
        solver_start = 1'b0;
        out_valid    = 1'b0;
        out_data     = '0;
        out_last     = 1'b0;
        out_fail     = 1'b0;
        busy         = 1'b1;
        case (state_q)
            ST_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            ST_START: solver_start = 1'b1;
            ST_UNLOAD: begin
                out_valid = 1'b1;
                out_data  = DW'(buf_q[idx_q*VW +: VW]);
                out_last  = (idx_q == IDX_LAST);
                out_fail  = fail_q;
            end
            default: ;
        endcase
    end

    assign solver_init = init_q;
    assign err_format  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_grid_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_grid_stream_bridge
// Brief   : Randomized self-checking bench for grid_stream_bridge (N=3 and N=2).
// Rev     : 1.0
// ============================================================================
module tb_grid_stream_bridge;
    localparam int A_W = 9, A_C = 81, A_VW = 4, A_TO = 64;
    localparam int B_W = 4, B_C = 16, B_VW = 3, B_TO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [63:0] onehot(input int v, input int w);
        return (v >= 1 && v <= w) ? (64'd1 << (v-1)) : 64'd0;
    endfunction

    // ---------------- instance A: N=3 ----------------
    logic          a_rst_L, a_in_valid, a_in_ready, a_start, a_done, a_sfail;
    logic [31:0]   a_in_data, a_out_data;
    logic [728:0]  a_init;
    logic [323:0]  a_vals, a_snap;
    logic          a_out_valid, a_out_ready, a_out_last, a_out_fail, a_busy, a_err;
    logic          a_err_m;
    int            a_puz [A_C];

    grid_stream_bridge #(.N(3), .DW(32), .TIMEOUT(A_TO)) u_a (
        .clk(clk), .rst_L(a_rst_L),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .solver_init(a_init), .solver_start(a_start), .solver_done(a_done),
        .solver_fail(a_sfail), .solver_vals(a_vals),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .out_fail(a_out_fail), .busy(a_busy), .err_format(a_err)
    );

    // ---------------- instance B: N=2 ----------------
    logic          b_rst_L, b_in_valid, b_in_ready, b_start, b_done, b_sfail;
    logic [7:0]    b_in_data, b_out_data;
    logic [63:0]   b_init;
    logic [47:0]   b_vals, b_snap;
    logic          b_out_valid, b_out_ready, b_out_last, b_out_fail, b_busy, b_err;
    logic          b_err_m;
    int            b_puz [B_C];

    grid_stream_bridge #(.N(2), .DW(8), .TIMEOUT(B_TO)) u_b (
        .clk(clk), .rst_L(b_rst_L),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .solver_init(b_init), .solver_start(b_start), .solver_done(b_done),
        .solver_fail(b_sfail), .solver_vals(b_vals),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .out_fail(b_out_fail), .busy(b_busy), .err_format(b_err)
    );

    // ---------------- A tasks ----------------
    task automatic load_a();
        check("a_ready_idle", 64'(a_in_ready), 64'(1));
        check("a_err_hold", 64'(a_err), 64'(a_err_m));
        for (int k = 0; k < A_C; k++) begin
            a_in_valid = 1'b1;
            a_in_data  = a_puz[k];
            @(posedge clk); #1;
            a_err_m = (k == 0 ? 1'b0 : a_err_m) | (a_puz[k] > A_W);
            check("a_err", 64'(a_err), 64'(a_err_m));
            if (k < A_C-1) check("a_start_early", 64'(a_start), 64'(0));
        end
        a_in_valid = 1'b0;
        check("a_start_pulse", 64'(a_start), 64'(1));
        check("a_busy", 64'(a_busy), 64'(1));
        check("a_ready_start", 64'(a_in_ready), 64'(0));
        for (int k = 0; k < A_C; k++)
            check("a_init", 64'(a_init[k*A_W +: A_W]), onehot(a_puz[k], A_W));
    endtask

    task automatic solve_a(input int done_at, input logic dfail, input int exp_rise, input logic exp_fail);
        int rise = 0;
        for (int k = 0; k < A_C; k++) a_vals[k*A_VW +: A_VW] = 4'($urandom_range(1, A_W));
        a_snap = a_vals;
        for (int c = 1; c <= 200 && rise == 0; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                check("a_start_once", 64'(a_start), 64'(0));
                check("a_ready_solve", 64'(a_in_ready), 64'(0));
            end
            if (a_out_valid) rise = c;
            else if (c == done_at) begin
                a_done  = 1'b1;
                a_sfail = dfail;
            end
        end
        a_done  = 1'b0;
        a_sfail = 1'b0;
        check("a_rise", 64'(rise), 64'(exp_rise));
        check("a_fail_flag", 64'(a_out_fail), 64'(exp_fail));
        for (int k = 0; k < A_C; k++) a_vals[k*A_VW +: A_VW] = 4'($urandom_range(0, 15));
    endtask

    task automatic unload_a(input logic stall, input logic exp_fail);
        logic [3:0] pat;
        int beat = 0;
        pat = 4'b1001;
        for (int cyc = 0; cyc < 2000 && beat < A_C; cyc++) begin
            a_out_ready = stall ? pat[cyc % 4] : 1'b1;
            if (stall) for (int k = 0; k < A_C; k++) a_vals[k*A_VW +: A_VW] = 4'($urandom_range(0, 15));
            @(negedge clk);
            if (a_out_valid) begin
                check("a_data", 64'(a_out_data), 64'(a_snap[beat*A_VW +: A_VW]));
                if (a_out_ready) begin
                    check("a_last", 64'(a_out_last), 64'(beat == A_C-1));
                    check("a_fail", 64'(a_out_fail), 64'(exp_fail));
                    beat++;
                end
            end else begin
                check("a_valid", 64'(a_out_valid), 64'(1));
            end
            @(posedge clk); #1;
        end
        a_out_ready = 1'b0;
        check("a_beats", 64'(beat), 64'(A_C));
        check("a_ready_after", 64'(a_in_ready), 64'(1));
        check("a_valid_after", 64'(a_out_valid), 64'(0));
    endtask

    // ---------------- B tasks ----------------
    task automatic load_b(input int ncells);
        check("b_ready_idle", 64'(b_in_ready), 64'(1));
        check("b_err_hold", 64'(b_err), 64'(b_err_m));
        for (int k = 0; k < ncells; k++) begin
            b_in_valid = 1'b1;
            b_in_data  = 8'(b_puz[k]);
            @(posedge clk); #1;
            b_err_m = (k == 0 ? 1'b0 : b_err_m) | (b_puz[k] > B_W);
            check("b_err", 64'(b_err), 64'(b_err_m));
            if (k < B_C-1) check("b_start_early", 64'(b_start), 64'(0));
        end
        b_in_valid = 1'b0;
        if (ncells == B_C) begin
            check("b_start_pulse", 64'(b_start), 64'(1));
            for (int k = 0; k < B_C; k++)
                check("b_init", 64'(b_init[k*B_W +: B_W]), onehot(b_puz[k], B_W));
        end
    endtask

    task automatic solve_b(input int done_at, input logic dfail, input int exp_rise, input logic exp_fail);
        int rise = 0;
        for (int k = 0; k < B_C; k++) b_vals[k*B_VW +: B_VW] = 3'($urandom_range(1, B_W));
        b_snap = b_vals;
        for (int c = 1; c <= 100 && rise == 0; c++) begin
            @(posedge clk); #1;
            if (b_out_valid) rise = c;
            else if (c == done_at) begin
                b_done  = 1'b1;
                b_sfail = dfail;
            end
        end
        b_done  = 1'b0;
        b_sfail = 1'b0;
        check("b_rise", 64'(rise), 64'(exp_rise));
        check("b_fail_flag", 64'(b_out_fail), 64'(exp_fail));
        for (int k = 0; k < B_C; k++) b_vals[k*B_VW +: B_VW] = 3'($urandom_range(0, 7));
    endtask

    task automatic unload_b(input logic exp_fail);
        int beat = 0;
        for (int cyc = 0; cyc < 200 && beat < B_C; cyc++) begin
            b_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (b_out_valid) begin
                check("b_data", 64'(b_out_data), 64'(b_snap[beat*B_VW +: B_VW]));
                if (b_out_ready) begin
                    check("b_last", 64'(b_out_last), 64'(beat == B_C-1));
                    check("b_fail", 64'(b_out_fail), 64'(exp_fail));
                    beat++;
                end
            end else begin
                check("b_valid", 64'(b_out_valid), 64'(1));
            end
            @(posedge clk); #1;
        end
        b_out_ready = 1'b0;
        check("b_beats", 64'(beat), 64'(B_C));
        check("b_ready_after", 64'(b_in_ready), 64'(1));
    endtask

    function automatic void rand_puz_b();
        for (int k = 0; k < B_C; k++) b_puz[k] = int'($urandom_range(0, B_W));
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int row0 [9];
        row0 = '{0, 2, 7, 0, 4, 0, 8, 0, 0};
        a_rst_L = 1'b0; a_in_valid = 1'b0; a_in_data = '0; a_done = 1'b0; a_sfail = 1'b0;
        a_vals = '0; a_out_ready = 1'b0; a_err_m = 1'b0;
        b_rst_L = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_done = 1'b0; b_sfail = 1'b0;
        b_vals = '0; b_out_ready = 1'b0; b_err_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a_rst_L = 1'b1;
        b_rst_L = 1'b1;
        @(posedge clk); #1;

        check("rst_in_ready", 64'(a_in_ready), 64'(1));
        check("rst_start", 64'(a_start), 64'(0));
        check("rst_out_valid", 64'(a_out_valid), 64'(0));
        check("rst_out_last", 64'(a_out_last), 64'(0));
        check("rst_out_fail", 64'(a_out_fail), 64'(0));
        check("rst_busy", 64'(a_busy), 64'(0));
        check("rst_err", 64'(a_err), 64'(0));
        check("rst_init", 64'(a_init == '0), 64'(1));

        // Known puzzle row 0, solver done after 40 cycles, no backpressure
        for (int k = 0; k < A_C; k++) a_puz[k] = (k < 9) ? row0[k] : int'($urandom_range(0, A_W));
        load_a();
        check("a_cell1_onehot", 64'(a_init[1*A_W +: A_W]), 64'(9'b000000010));
        solve_a(40, 1'b0, 41, 1'b0);
        unload_a(1'b0, 1'b0);

        // Solver reports contradiction; stalled unload with changing solver_vals
        for (int k = 0; k < A_C; k++) a_puz[k] = int'($urandom_range(0, A_W));
        load_a();
        solve_a(10, 1'b1, 11, 1'b1);
        unload_a(1'b1, 1'b1);

        // Out-of-range value in cell 5
        for (int k = 0; k < A_C; k++) a_puz[k] = int'($urandom_range(0, A_W));
        a_puz[5] = 12;
        load_a();
        check("a_cell5_zero", 64'(a_init[5*A_W +: A_W]), 64'(0));
        solve_a(20, 1'b0, 21, 1'b0);
        unload_a(1'b0, 1'b0);
        check("a_err_persist", 64'(a_err), 64'(1));

        // Next legal puzzle clears err_format on its first handshake
        for (int k = 0; k < A_C; k++) a_puz[k] = int'($urandom_range(0, A_W));
        load_a();
        solve_a(5, 1'b0, 6, 1'b0);
        unload_a(1'b1, 1'b0);

        // N=2: timeout, done coinciding with timeout, ordinary fail
        rand_puz_b();
        load_b(B_C);
        solve_b(0, 1'b0, 17, 1'b1);
        unload_b(1'b1);
        rand_puz_b();
        load_b(B_C);
        solve_b(16, 1'b0, 17, 1'b0);
        unload_b(1'b0);
        rand_puz_b();
        load_b(B_C);
        solve_b(3, 1'b1, 4, 1'b1);
        unload_b(1'b1);

        // N=2: reset while cell 7 is presented
        rand_puz_b();
        b_puz[2] = 7;
        load_b(7);
        b_in_valid = 1'b1;
        b_in_data  = 8'(b_puz[7]);
        #2;
        b_rst_L    = 1'b0;
        b_in_valid = 1'b0;
        #1;
        check("b_rst_in_ready", 64'(b_in_ready), 64'(1));
        check("b_rst_busy", 64'(b_busy), 64'(0));
        check("b_rst_err", 64'(b_err), 64'(0));
        check("b_rst_init", 64'(b_init), 64'(0));
        @(posedge clk); #1;
        b_rst_L = 1'b1;
        b_err_m = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("b_rst_no_start", 64'(b_start), 64'(0));
        end
        rand_puz_b();
        load_b(B_C);
        solve_b(7, 1'b0, 8, 1'b0);
        unload_b(1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/grid_stream_bridge.md
Name: grid_stream_bridge

Overview:
- Parametrised host-side transfer engine for the constraint-propagation grid solver, for any box size N (grid side WIDTH = N*N).
- Streams a row-major puzzle in over a valid/ready channel, decodes each cell to one-hot, and pulses the solver start.
- Waits for solver completion or a timeout, snapshots the results into a buffer, and streams them out with full backpressure, a last marker and a fail flag.

Parameters:
- N, 3, box size; WIDTH = N*N (derived), CELLS = WIDTH*WIDTH (derived), VW = $clog2(WIDTH+1) (derived value width).
- DW, 32, stream data width; must be >= VW.
- TIMEOUT, 1024, maximum cycles in SOLVE before a forced fail; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst_L  in  1  reset, asynchronous, active-low
- in_valid  in  1  input cell valid
- in_ready  out  1  input cell accepted when in_valid && in_ready
- in_data  in  DW  cell value, unsigned: 0 = blank, 1..WIDTH = given
- solver_init  out  CELLS*WIDTH  one-hot initial grid; cell k at bits [k*WIDTH +: WIDTH]
- solver_start  out  1  one-cycle load pulse to the solver
- solver_done  in  1  solver finished (level)
- solver_fail  in  1  solver contradiction (level, sampled with done)
- solver_vals  in  CELLS*VW  binary result per cell, cell k at [k*VW +: VW]
- out_valid  out  1  result cell valid
- out_ready  in  1  downstream accepts
- out_data  out  DW  result value, zero-extended from VW
- out_last  out  1  high with cell CELLS-1
- out_fail  out  1  puzzle failed (solver fail or timeout); constant over one result stream
- busy  out  1  state != LOAD
- err_format  out  1  sticky: an input value > WIDTH was seen in the current puzzle

Behaviour:
- State machine LOAD -> START -> SOLVE -> UNLOAD -> LOAD. Reset enters LOAD.
- Reset values: idx=0, solver_init=0, result buffer=0, fail latch=0, err_format=0, timer=0.
  - Outputs in LOAD: in_ready=1, solver_start=0, out_valid=0, out_last=0, out_fail=0, busy=0.
- LOAD:
  - in_ready=1. Each handshake writes decode(in_data) to cell idx, then idx++.
  - decode: v in 1..WIDTH -> bit v-1 set; v=0 or v>WIDTH -> all zero.
  - v>WIDTH also sets err_format.
  - The handshake at idx=0 clears err_format first; the same-cycle error set wins.
  - On the handshake at idx=CELLS-1: idx->0, go to START.
- START:
  - Exactly one cycle. solver_start=1, in_ready=0, busy=1. Timer cleared.
  - Latency: last input handshake at cycle t -> solver_start high at t+1 -> SOLVE from t+2.
- SOLVE:
  - in_ready=0. Timer increments every cycle.
  - solver_done=1: capture solver_vals into the result buffer, latch fail=solver_fail, go to UNLOAD.
  - Else if TIMEOUT!=0 and timer==TIMEOUT-1: capture solver_vals, latch fail=1, go to UNLOAD.
  - If done and timeout coincide, done wins and fail=solver_fail.
  - out_valid rises the cycle after the exit condition.
- UNLOAD:
  - out_valid=1. out_data = buffer[idx], out_fail = fail latch, out_last = (idx==CELLS-1).
  - All outputs are driven from registers/buffer and are stable while out_valid && !out_ready.
  - The buffer is immune to solver_vals changes after capture.
  - Each handshake: idx++. The handshake with out_last: idx->0, go to LOAD; in_ready=1 the next cycle.
  - in_valid is ignored outside LOAD; no input is consumed.
- solver_init holds its value after START until overwritten cell by cell in the next LOAD. No bulk clear.
- err_format persists through SOLVE and UNLOAD.
- Reset asserted mid-operation: immediate return to the reset values above. A partial puzzle or result stream is discarded; no start pulse is issued.
- idx is $clog2(CELLS) bits and never exceeds CELLS-1. The timer saturates at TIMEOUT-1.

Test Plan:
- N=3: stream 81 cells of a known solvable puzzle (row 0 = 0,2,7,0,4,0,8,0,0), in_valid held high.
  - Required: cell 1 one-hot = 9'b000000010; solver_start high exactly 1 cycle, 1 cycle after the 81st handshake.
- Solver model asserts done with fail=0 after 40 cycles, out_ready always high.
  - Required: 81 outputs matching the model values, out_last only on beat 81, out_fail=0, in_ready=1 the next cycle.
- out_ready toggled 1,0,0,1 repeatedly during unload.
  - Required: no dropped or duplicated beats; out_data stable across stalls.
  - Solver changes solver_vals after capture -> outputs unaffected.
- TIMEOUT=16, done never asserted.
  - Required: out_valid rises 17 cycles after START with out_fail=1. A done coinciding with the timeout cycle takes the solver_fail value.
- Cell 5 value 12, other cells legal.
  - Required: cell 5 stored as 0, err_format=1 until the first handshake of the next puzzle, then 0.
- N=2 (CELLS=16, VW=3): full load/solve/unload cycle works.
  - rst_L pulsed low at input cell 7: in_ready=1, idx=0, no solver_start, err_format=0, busy=0.
